// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx_fifo
//  Purpose  : PS/2 keyboard receiver. It synchronises and glitch-filters the
//             raw lines, deframes 11-bit frames with parity, stop and timeout
//             checks, folds the 0xE0/0xF0 prefixes into flags, and queues key
//             events in a first-word-fall-through FIFO.
//  Options  : PS2_TYPEMATIC_FILTER_EN - drops an auto-repeated make code until
//             the break code for that key has been queued.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                              clk,
   input  logic                              rst_l,
   input  logic                              ps2_clk,
   input  logic                              ps2_data,
   input  logic                              rd_en,
   input  logic                              clr_err,
   output logic                              key_valid,
   output logic [7:0]                        key_code,
   output logic                              key_ext,
   output logic                              key_break,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              overflow,
   output logic                              parity_err,
   output logic                              frame_err
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_CW = $clog2(FIFO_DEPTH + 1);
   localparam int c_FW = $clog2(FILTER_LEN + 1);
   localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Front end
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic [c_FW-1:0]        r_filt_cnt;
   logic                   r_filt_clk;
   logic                   r_filt_clk_d;
   logic                   w_sclk;
   logic                   w_data;
   logic                   w_fall;

   assign w_sclk = r_clk_sync[SYNC_STAGES-1];
   assign w_data = r_data_sync[SYNC_STAGES-1];
   assign w_fall = r_filt_clk_d & ~r_filt_clk;

   // Synchronisers; idle PS/2 lines are high, so reset to 1.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      end
   end

   // Filtered clock follows the synchronised clock only after FILTER_LEN
   // consecutive samples at the new level.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_filt_cnt   <= '0;
         r_filt_clk   <= 1'b1;
         r_filt_clk_d <= 1'b1;
      end else begin
         r_filt_clk_d <= r_filt_clk;
         if (w_sclk == r_filt_clk) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == c_FW'(FILTER_LEN - 1)) begin
            r_filt_clk <= w_sclk;
            r_filt_cnt <= '0;
         end else begin
            r_filt_cnt <= r_filt_cnt + c_FW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t          r_state, w_state_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic [2:0]      r_bitcnt, w_bitcnt_nxt;
   logic            r_par, w_par_nxt;
   logic [c_TW-1:0] r_tcnt, w_tcnt_nxt;
   logic            w_accept, w_par_err, w_frame_err;
   logic            r_accept, r_par_err, r_frame_err;

   // Frame state register plus registered result pulses.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_bitcnt    <= '0;
         r_par       <= 1'b0;
         r_tcnt      <= '0;
         r_accept    <= 1'b0;
         r_par_err   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_par       <= w_par_nxt;
         r_tcnt      <= w_tcnt_nxt;
         r_accept    <= w_accept;
         r_par_err   <= w_par_err;
         r_frame_err <= w_frame_err;
      end
   end

   // Deframing on fall events, with the timeout overriding a stalled frame.
   always_comb begin
      w_state_nxt  = r_state;
      w_shift_nxt  = r_shift;
      w_bitcnt_nxt = r_bitcnt;
      w_par_nxt    = r_par;
      w_tcnt_nxt   = '0;
      w_accept     = 1'b0;
      w_par_err    = 1'b0;
      w_frame_err  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_fall) begin
               if (!w_data) begin
                  w_state_nxt  = ST_DATA;
                  w_bitcnt_nxt = 3'd0;
               end else begin
                  w_frame_err = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (w_fall) begin
               w_shift_nxt  = {w_data, r_shift[7:1]};
               w_bitcnt_nxt = r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) begin
                  w_state_nxt = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (w_fall) begin
               w_par_nxt   = w_data;
               w_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_fall) begin
               w_state_nxt = ST_IDLE;
               if (!w_data) begin
                  w_frame_err = 1'b1;
               end else if (^{r_shift, r_par}) begin
                  w_accept = 1'b1;
               end else begin
                  w_par_err = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if ((r_state != ST_IDLE) && !w_fall) begin
         if (r_tcnt == c_TW'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt = ST_IDLE;
            w_frame_err = 1'b1;
         end else begin
            w_tcnt_nxt = r_tcnt + c_TW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Prefix decode and FIFO
   // ------------------------------------------------------------------
   logic                  r_ext, r_brk;
   logic [9:0]            r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]       r_wr_ptr, r_rd_ptr;
   logic [c_CW-1:0]       r_count;
   logic                  r_overflow;
   logic                  w_is_prefix, w_suppress, w_push_req, w_push, w_pop, w_full;
   logic [9:0]            w_entry, w_head;

   assign w_is_prefix = (r_shift == 8'hE0) || (r_shift == 8'hF0);
   assign w_entry     = {r_ext, r_brk, r_shift};
   assign w_push_req  = r_accept & ~w_is_prefix & ~w_suppress;
   assign w_full      = (r_count == c_CW'(FIFO_DEPTH));
   assign w_pop       = rd_en & (r_count != '0);
   assign w_push      = w_push_req & (~w_full | w_pop);

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic       r_tm_valid;
   logic [8:0] r_tm_key;

   assign w_suppress = r_accept & ~r_brk & r_tm_valid & (r_tm_key == {r_ext, r_shift});

   // Remember the last queued make; its queued break re-arms that key.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_tm_valid <= 1'b0;
         r_tm_key   <= '0;
      end else if (w_push) begin
         if (!r_brk) begin
            r_tm_valid <= 1'b1;
            r_tm_key   <= {r_ext, r_shift};
         end else if (r_tm_key == {r_ext, r_shift}) begin
            r_tm_valid <= 1'b0;
         end
      end
   end
`else
   assign w_suppress = 1'b0;
`endif

   // Prefix flags: set by E0/F0, consumed by any other byte or any error.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_ext <= 1'b0;
         r_brk <= 1'b0;
      end else if (r_par_err || r_frame_err) begin
         r_ext <= 1'b0;
         r_brk <= 1'b0;
      end else if (r_accept) begin
         if (r_shift == 8'hE0) begin
            r_ext <= 1'b1;
         end else if (r_shift == 8'hF0) begin
            r_brk <= 1'b1;
         end else begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
         end
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   // Pointers, occupancy and the sticky overflow flag (set beats clear).
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_push_req && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end else if (clr_err) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign w_head     = r_mem[r_rd_ptr];
   assign key_valid  = (r_count != '0);
   assign key_code   = key_valid ? w_head[7:0] : 8'h00;
   assign key_break  = key_valid & w_head[8];
   assign key_ext    = key_valid & w_head[9];
   assign fifo_count = r_count;
   assign overflow   = r_overflow;
   assign parity_err = r_par_err;
   assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_rx_fifo
//  Purpose  : Self-checking bench for ps2_rx_fifo. A frame-level queue model
//             predicts the FIFO contents, flags and error pulse counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

   localparam int DEPTH = 8;
   localparam int TMO   = 2000;
   localparam int HALF  = 20;

   logic       clk = 1'b0;
   logic       rst_l = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic       clr_err = 1'b0;
   logic       key_valid, key_ext, key_break, overflow, parity_err, frame_err;
   logic [7:0] key_code;
   logic [3:0] fifo_count;

   ps2_rx_fifo #(
      .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_l(rst_l), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd_en(rd_en), .clr_err(clr_err), .key_valid(key_valid),
      .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
      .fifo_count(fifo_count), .overflow(overflow),
      .parity_err(parity_err), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Model state
   logic [9:0] q[$];
   bit         m_ext, m_brk, m_ovf, tm_v;
   logic [8:0] tm_k;
   int         exp_perr = 0, exp_ferr = 0;
   bit         chk_en = 1'b0;
   bit         pin_on = 1'b0;
   logic [7:0] pin_code;
   bit         pin_ext, pin_brk;
   int         pin_cnt;

   // Compare-process state
   int checks = 0, errors = 0;
   int perr_seen = 0, ferr_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // Single compare process: model vs DUT on every settled cycle.
   always @(negedge clk) begin
      if (parity_err) perr_seen++;
      if (frame_err)  ferr_seen++;
      if (!rst_l) begin
         chk("rst_code", 32'(key_code), 32'h0);
         chk("rst_ext_brk", 32'({key_ext, key_break}), 32'h0);
         chk("rst_pulses", 32'({parity_err, frame_err}), 32'h0);
      end
      if (chk_en) begin
         chk("valid", 32'(key_valid), 32'(q.size() != 0));
         chk("count", 32'(fifo_count), 32'(q.size()));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("parity_pulses", 32'(perr_seen), 32'(exp_perr));
         chk("frame_pulses", 32'(ferr_seen), 32'(exp_ferr));
         if (q.size() != 0) begin
            chk("code", 32'(key_code), 32'(q[0][7:0]));
            chk("ext", 32'(key_ext), 32'(q[0][9]));
            chk("brk", 32'(key_break), 32'(q[0][8]));
         end
      end
      if (pin_on) begin
         chk("pin_count", 32'(fifo_count), 32'(pin_cnt));
         if (pin_cnt != 0) begin
            chk("pin_code", 32'(key_code), 32'(pin_code));
            chk("pin_ext", 32'(key_ext), 32'(pin_ext));
            chk("pin_brk", 32'(key_break), 32'(pin_brk));
         end
      end
   end

   function automatic void model_reset();
      q.delete();
      m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; tm_v = 1'b0;
   endfunction

   // Outcome of one complete frame, from the protocol rules.
   function automatic void model_byte(input logic [7:0] code, input bit badp, input bit bads);
      bit supp;
      if (bads) begin
         exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
      end else if (badp) begin
         exp_perr++; m_ext = 1'b0; m_brk = 1'b0;
      end else if (code == 8'hE0) begin
         m_ext = 1'b1;
      end else if (code == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         supp = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
         if (!m_brk && tm_v && tm_k == {m_ext, code}) supp = 1'b1;
`endif
         if (!supp) begin
            if (q.size() < DEPTH) begin
               q.push_back({m_ext, m_brk, code});
               if (!m_brk) begin
                  tm_v = 1'b1; tm_k = {m_ext, code};
               end else if (tm_k == {m_ext, code}) begin
                  tm_v = 1'b0;
               end
            end else begin
               m_ovf = 1'b1;
            end
         end
         m_ext = 1'b0; m_brk = 1'b0;
      end
   endfunction

   task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         repeat (8) @(posedge clk);
         if (glitch && i == 3) begin
            ps2_clk = 1'b0;
            repeat (2) @(posedge clk);
            ps2_clk = 1'b1;
         end
         repeat (12) @(posedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input bit badp = 1'b0,
                             input bit bads = 1'b0, input bit glitch = 1'b0);
      logic [10:0] f;
      f = {~bads, (~^code) ^ badp, code, 1'b0};
      chk_en = 1'b0;
      send_bits(f, 11, glitch);
      repeat (30) @(posedge clk);
      model_byte(code, badp, bads);
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic pop();
      @(negedge clk) rd_en = 1'b1;
      @(posedge clk);
      if (q.size() > 0) void'(q.pop_front());
      @(negedge clk) rd_en = 1'b0;
   endtask

   task automatic clr();
      @(negedge clk) clr_err = 1'b1;
      @(posedge clk) m_ovf = 1'b0;
      @(negedge clk) clr_err = 1'b0;
   endtask

   task automatic pin(input logic [7:0] c, input bit e, input bit b, input int n);
      @(posedge clk);
      pin_code = c; pin_ext = e; pin_brk = b; pin_cnt = n; pin_on = 1'b1;
      @(posedge clk);
      pin_on = 1'b0;
   endtask

   task automatic drain();
      while (q.size() > 0) pop();
   endtask

   initial begin
      logic [7:0] code;
      int         r;
      model_reset();
      chk_en = 1'b1;
      repeat (5) @(posedge clk);
      rst_l = 1'b1;
      repeat (5) @(posedge clk);

      // Clean make code
      send_frame(8'h1C);
      pin(8'h1C, 1'b0, 1'b0, 1);
      pop();

      // Prefix folding
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
      pin(8'h75, 1'b1, 1'b1, 1);
      send_frame(8'h1C);
      pop();
      pin(8'h1C, 1'b0, 1'b0, 1);
      pop();

      // Bad parity, then a good frame
      send_frame(8'h1C, 1'b1);
      pin(8'h00, 1'b0, 1'b0, 0);
      send_frame(8'h1C);
      pop();

      // Bad stop alone and with bad parity; prefix discarded by the error
      send_frame(8'hF0);
      send_frame(8'h5A, 1'b0, 1'b1);
      send_frame(8'h5A, 1'b1, 1'b1);
      send_frame(8'h22);
      pin(8'h22, 1'b0, 1'b0, 1);
      pop();

      // Timeout after a prefix
      send_frame(8'hE0);
      chk_en = 1'b0;
      send_bits({2'b11, 8'h29, 1'b0}, 4, 1'b0);
      repeat (TMO + 10) @(posedge clk);
      exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
      chk_en = 1'b1;
      send_frame(8'h29);
      pin(8'h29, 1'b0, 1'b0, 1);
      pop();

      // Glitches: idle and mid-frame
      @(posedge clk) ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(posedge clk);
      send_frame(8'h33, 1'b0, 1'b0, 1'b1);
      pin(8'h33, 1'b0, 1'b0, 1);
      pop();

      // Overflow and ordering
      for (int i = 1; i <= 9; i++) send_frame(8'(i));
      for (int i = 0; i < 8; i++) begin
         pin(8'(i + 1), 1'b0, 1'b0, 8 - i);
         pop();
      end
      pop();
      clr();

      // Typematic sequence
      send_frame(8'h1C); send_frame(8'h1C);
      send_frame(8'hF0); send_frame(8'h1C);
      send_frame(8'h1C);
      drain();

      // Randomised traffic
      repeat (40) begin
         r = $urandom_range(0, 11);
         if (r == 0)      code = 8'hE0;
         else if (r == 1) code = 8'hF0;
         else if (r < 6)  code = 8'($urandom_range(1, 4));
         else             code = 8'($urandom_range(0, 255));
         send_frame(code, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 5) == 0);
         repeat ($urandom_range(0, 2)) pop();
         if ($urandom_range(0, 4) == 0) clr();
      end

      // Reset in the middle of a frame discards everything
      send_frame(8'h11); send_frame(8'h12);
      chk_en = 1'b0;
      send_bits({2'b11, 8'h55, 1'b0}, 5, 1'b0);
      @(posedge clk);
      rst_l = 1'b0;
      model_reset();
      chk_en = 1'b1;
      repeat (5) @(posedge clk);
      rst_l = 1'b1;
      repeat (5) @(posedge clk);
      send_frame(8'h13);
      pin(8'h13, 1'b0, 1'b0, 1);
      drain();

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
